// File: rtl/flight_call_arbiter_if.sv
// Attendant-panel handshake bundle for flight_call_arbiter: dispatch offer,
// acceptance, completion and service status.
interface flight_call_arbiter_if #(
    parameter int IDX_W = 3
);
    logic             req_valid;
    logic [IDX_W-1:0] req_seat;
    logic             req_ready;
    logic             done;
    logic             busy;
    logic             overdue;

    modport master (
        output req_valid,
        output req_seat,
        output busy,
        output overdue,
        input  req_ready,
        input  done
    );

    modport slave (
        input  req_valid,
        input  req_seat,
        input  busy,
        input  overdue,
        output req_ready,
        output done
    );
endinterface

// File: rtl/flight_call_arbiter.sv
// Cabin call controller: latches seat call requests, drives call lights and
// shares one attendant between pending seats with round-robin dispatch.
module flight_call_arbiter #(
    parameter int N_SEATS = 8,
    parameter int IDX_W   = $clog2(N_SEATS),
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SEATS-1:0] call,
    input  logic [N_SEATS-1:0] cncl,
    output logic [N_SEATS-1:0] light,
    flight_call_arbiter_if.master att
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OFFER   = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [N_SEATS-1:0] pending_r;
    logic [N_SEATS-1:0] pending_nx_s;
    logic [1:0]         state_r;
    logic [1:0]         state_nx_s;
    logic [IDX_W-1:0]   last_grant_r;
    logic [IDX_W-1:0]   seat_r;
    logic [IDX_W-1:0]   sel_s;
    logic [IDX_W-1:0]   cand_s;
    logic [IDX_W:0]     sum_s;
    logic [CNT_W-1:0]   timer_r;
    logic [CNT_W-1:0]   timer_nx_s;
    logic               req_valid_r;
    logic               busy_r;
    logic               overdue_r;
    logic               svc_done_s;

    assign svc_done_s = (state_r == ST_SERVICE) && att.done;

    // Next pending vector: a press wins over both cancel and completion.
    always_comb begin
        pending_nx_s = pending_r;
        for (int i = 0; i < N_SEATS; i++) begin
            pending_nx_s[i] = call[i] |
                              (pending_r[i] & ~cncl[i] &
                               ~(svc_done_s && (seat_r == IDX_W'(i))));
        end
    end

    // Round-robin pick: scan downward so the nearest seat after last_grant wins.
    always_comb begin
        sel_s  = {IDX_W{1'b0}};
        sum_s  = {(IDX_W+1){1'b0}};
        cand_s = {IDX_W{1'b0}};
        for (int k = N_SEATS; k >= 1; k--) begin
            sum_s  = {1'b0, last_grant_r} + (IDX_W+1)'(k);
            cand_s = (sum_s >= (IDX_W+1)'(N_SEATS)) ?
                     IDX_W'(sum_s - (IDX_W+1)'(N_SEATS)) : sum_s[IDX_W-1:0];
            sel_s  = pending_r[cand_s] ? cand_s : sel_s;
        end
    end

    // Dispatch FSM next state and service timer.
    always_comb begin
        state_nx_s = state_r;
        timer_nx_s = timer_r;
        case (state_r)
            ST_IDLE: begin
                if (|pending_r) state_nx_s = ST_OFFER;
                else            state_nx_s = ST_IDLE;
            end
            ST_OFFER: begin
                if (!pending_r[seat_r]) begin
                    state_nx_s = ST_IDLE;
                end else if (att.req_ready) begin
                    state_nx_s = ST_SERVICE;
                    timer_nx_s = {CNT_W{1'b0}};
                end else begin
                    state_nx_s = ST_OFFER;
                end
            end
            ST_SERVICE: begin
                if (att.done) begin
                    state_nx_s = ST_IDLE;
                    timer_nx_s = {CNT_W{1'b0}};
                end else begin
                    state_nx_s = ST_SERVICE;
                    timer_nx_s = (timer_r == {CNT_W{1'b1}}) ? timer_r
                                                            : timer_r + CNT_W'(1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                timer_nx_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, pending and output registers; outputs decode the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r    <= {N_SEATS{1'b0}};
            state_r      <= ST_IDLE;
            last_grant_r <= IDX_W'(N_SEATS - 1);
            seat_r       <= {IDX_W{1'b0}};
            timer_r      <= {CNT_W{1'b0}};
            req_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            overdue_r    <= 1'b0;
        end else begin
            pending_r   <= pending_nx_s;
            state_r     <= state_nx_s;
            timer_r     <= timer_nx_s;
            req_valid_r <= (state_nx_s == ST_OFFER);
            busy_r      <= (state_nx_s == ST_SERVICE);
            overdue_r   <= (state_nx_s == ST_SERVICE) &&
                           (timer_nx_s >= CNT_W'(TIMEOUT));
            if ((state_r == ST_IDLE) && (|pending_r)) begin
                seat_r <= sel_s;
            end
            if (svc_done_s) begin
                last_grant_r <= seat_r;
            end
        end
    end

    assign light         = pending_r;
    assign att.req_valid = req_valid_r;
    assign att.req_seat  = seat_r;
    assign att.busy      = busy_r;
    assign att.overdue   = overdue_r;
endmodule
